// File: rtl/inst_word_tx_if.sv
// inst_word_tx_if: producer-side opcode handshake and byte-wide output link of the instruction-word transmitter
interface inst_word_tx_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instruction;
  logic [15:0] in_absolute;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        busy;
  modport slave (
    input  in_valid, in_instruction, in_absolute, out_ready,
    output in_ready, out_valid, out_byte, out_last, busy
  );
  modport master (
    output in_valid, in_instruction, in_absolute, out_ready,
    input  in_ready, out_valid, out_byte, out_last, busy
  );
endinterface

// File: rtl/inst_word_tx.sv
// inst_word_tx: packs {instruction, absolute} into 32-bit words, queues them and streams them out bytewise.
// Optional INST_WORD_TX_PARITY_EN appends an XOR parity byte to every frame.
module inst_word_tx #(
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  inst_word_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef INST_WORD_TX_PARITY_EN
  localparam int IW = 3;
  localparam logic [IW-1:0] LAST = 3'd4;
`else
  localparam int IW = 2;
  localparam logic [IW-1:0] LAST = 2'd3;
`endif
  typedef enum logic {IDLE, SEND} state_t;
  state_t          r_state, w_state_nx;
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_cnt;
  logic            r_rdy;
  logic [31:0]     r_word;
  logic [IW-1:0]   r_idx;
  logic            w_empty, w_full, w_push, w_pop, w_xfer, w_final;
  logic [4:0]      w_sh;
  logic [7:0]      w_wb, w_byte;
  assign w_empty = r_cnt == '0;
  assign w_full  = r_cnt == CW'(DEPTH);
  // r_rdy keeps in_ready low until the first edge after reset release
  assign bus.in_ready = r_rdy && !w_full;
  assign w_push  = bus.in_valid && bus.in_ready;
  assign w_xfer  = bus.out_valid && bus.out_ready;
  assign w_final = w_xfer && bus.out_last;
  assign w_pop   = !w_empty && (r_state == IDLE || w_final);
  assign w_sh = {(MSB_FIRST ? ~r_idx[1:0] : r_idx[1:0]), 3'b000};
  assign w_wb = r_word[w_sh +: 8];
`ifdef INST_WORD_TX_PARITY_EN
  assign w_byte = (r_idx == LAST) ? (r_word[31:24] ^ r_word[23:16] ^ r_word[15:8] ^ r_word[7:0]) : w_wb;
`else
  assign w_byte = w_wb;
`endif
  assign bus.out_valid = r_state == SEND;
  assign bus.out_last  = r_state == SEND && r_idx == LAST;
  assign bus.out_byte  = r_state == SEND ? w_byte : 8'd0;
  assign bus.busy      = r_state == SEND || !w_empty;
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = r_state == IDLE ? (w_empty ? IDLE : SEND) : ((w_final && w_empty) ? IDLE : SEND);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_rdy   <= 1'b0;
      r_word  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_rdy   <= 1'b1;
      r_cnt   <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) begin
        r_rp   <= r_rp + AW'(1);
        r_word <= r_mem[r_rp];
      end
      r_idx <= (w_pop || w_final) ? '0 : w_xfer ? r_idx + IW'(1) : r_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {bus.in_instruction, bus.in_absolute};
  end
endmodule
